ir_command_decoder: RTL and testbench
=====================================

Name: ir_command_decoder

Overview:
- Sits directly downstream of the IR receiver. Consumes its 32-bit NEC frame word and data-ready strobe.
- Validates the address and command complement fields and filters frames by address.
- Tags auto-repeat presses and queues key codes in a small FIFO with a pop handshake, for the display or control logic.
- Also tracks key-held state, overflow, and an error count.

Parameters:
ADDRESS, 16'h0000, address accepted when CHECK_ADDRESS=1
CHECK_ADDRESS, 1, 1 = drop frames whose address differs from ADDRESS
EXTENDED_ADDR, 0, 1 = 16-bit NEC extended address (no address complement check)
FIFO_DEPTH, 4, key FIFO entries; power of 2, >=2
RELEASE_CYCLES, 6000000, key-held window in clocks (120 ms at 50 MHz)
ERR_WIDTH, 8, error counter width

Ports:
i_CLOCK_POS  in  1  system clock, rising edge
i_RESET_POS  in  1  synchronous reset, active-high
i_DATA_READY  in  1  frame-valid level from IR receiver
i_DATA  in  32  frame: [7:0] addr, [15:8] ~addr (or addr high), [23:16] cmd, [31:24] ~cmd
i_POP  in  1  consumer removes head entry
o_KEY_VALID  out  1  FIFO not empty
o_KEY_CODE  out  8  head command (first-word fall-through)
o_KEY_REPEAT  out  1  head entry is a repeat of the previous valid key
o_KEY_HELD  out  1  release timer nonzero
o_FIFO_FULL  out  1  FIFO full
o_OVERFLOW  out  1  sticky: a valid key was dropped because the FIFO was full
o_ERROR_COUNT  out  ERR_WIDTH  saturating count of malformed or dropped frames
o_LAST_ADDRESS  out  16  address of last complement-valid frame

Behaviour:
- Reset (synchronous, i_RESET_POS=1 at edge):
  - All outputs 0; FIFO emptied; state IDLE; release timer 0.
  - last-key-valid flag cleared; edge-detect register cleared.
- Edge detect: a frame event is a cycle where i_DATA_READY=1 and its registered copy is 0. A level held high yields one event.
- FSM IDLE -> CHECK -> PUSH -> IDLE:
  - IDLE: on event at edge N, capture i_DATA and go to CHECK.
  - CHECK (edge N+1), in this order:
    - If cmd != ~cmd field: error_count+1, go to IDLE.
    - Else if EXTENDED_ADDR=0 and addr != ~addr field: error_count+1, go to IDLE.
    - Else update o_LAST_ADDRESS ({8'h00,addr}, or data[15:0] if EXTENDED_ADDR).
    - If CHECK_ADDRESS and address != ADDRESS: go to IDLE silently (no error).
    - Otherwise go to PUSH.
  - PUSH (edge N+2):
    - repeat = last_valid && cmd==last_cmd && timer!=0.
    - Write {repeat,cmd} to FIFO; last_cmd<=cmd; last_valid<=1; timer<=RELEASE_CYCLES.
    - o_KEY_VALID visible after edge N+2 when the FIFO was empty.
- Event while FSM is not IDLE: frame dropped, error_count+1.
- Release timer:
  - Decrements by 1 per clock to 0 and holds at 0.
  - A load in PUSH overrides the decrement.
  - o_KEY_HELD = (timer != 0).
- FIFO:
  - Pop when i_POP && o_KEY_VALID; i_POP while empty is ignored.
  - Push while full and no pop: entry dropped, o_OVERFLOW<=1 (cleared only by reset), error count unchanged.
  - Push and pop in the same cycle while full: both succeed, occupancy unchanged.
  - Pointer wrap is modulo FIFO_DEPTH.
- o_ERROR_COUNT saturates at all ones.
- Reset mid-frame (any FSM state): return to IDLE, in-flight frame discarded.

Decomposition:
- Package ir_pkg:
  - NEC field bit positions (ADDR_LSB, NADDR_LSB, CMD_LSB, NCMD_LSB).
  - FSM state encoding (IDLE, CHECK, PUSH).
  - FIFO entry width (9 = repeat + code).
- One sub-module, ir_key_fifo:
  - Synchronous first-word-fall-through FIFO, parameterised depth and width.
  - Outputs: full, empty, head.

Test Plan:
- Defaults, i_DATA=32'hBF40FF00, rising i_DATA_READY -> o_KEY_VALID=1 two edges after capture, o_KEY_CODE=8'h40, o_KEY_REPEAT=0, o_LAST_ADDRESS=16'h0000, o_KEY_HELD=1.
- RELEASE_CYCLES=100: same frame again 50 clocks later -> second entry has repeat=1. Same frame 150 clocks after that -> repeat=0. o_KEY_HELD falls exactly 100 clocks after the last PUSH.
- i_DATA=32'hBE40FF00 (bad ~cmd) -> no FIFO entry, o_ERROR_COUNT=1. i_DATA=32'hBF40FE00 (bad ~addr) -> o_ERROR_COUNT=2.
- CHECK_ADDRESS=1, ADDRESS=16'h0000, i_DATA=32'hBF40FE01 -> no entry, o_ERROR_COUNT unchanged, o_LAST_ADDRESS=16'h0001.
- FIFO_DEPTH=4, five valid frames with no pop -> o_FIFO_FULL=1, o_OVERFLOW=1, head=first code. Pop four times -> codes in order, then o_KEY_VALID=0. Extra i_POP while empty -> no change.
- i_RESET_POS asserted during CHECK -> no entry pushed, all outputs 0 next cycle. Holding i_DATA_READY high for 1000 clocks -> exactly one entry.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared definitions for the NEC IR command decoder: frame field positions,
// FSM encoding and the layout of a queued key entry.
package ir_pkg;

    localparam int ADDR_LSB  = 0;
    localparam int NADDR_LSB = 8;
    localparam int CMD_LSB   = 16;
    localparam int NCMD_LSB  = 24;

    localparam int ENTRY_W = 9;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_PUSH  = 2'd2;

    typedef struct packed {
        logic       rpt;
        logic [7:0] code;
    } key_entry_t;

    function automatic logic [7:0] nec_field(input logic [31:0] frame, input int lsb);
        return frame[lsb +: 8];
    endfunction

endpackage

// File: rtl/ir_key_fifo.sv
// Synchronous first-word-fall-through FIFO holding decoded key entries.
// A push into a full FIFO only succeeds when a pop happens in the same cycle.
module ir_key_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Depth is a power of two, so pointer wrap is natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ir_command_decoder.sv
// Validates NEC frames from the IR receiver, filters by address, tags repeats
// and queues key codes for the consumer; tracks key-held, overflow and errors.
module ir_command_decoder
    import ir_pkg::*;
#(
    parameter logic [15:0] ADDRESS        = 16'h0000,
    parameter bit          CHECK_ADDRESS  = 1'b1,
    parameter bit          EXTENDED_ADDR  = 1'b0,
    parameter int          FIFO_DEPTH     = 4,
    parameter int          RELEASE_CYCLES = 6000000,
    parameter int          ERR_WIDTH      = 8
) (
    input  logic                 i_CLOCK_POS,
    input  logic                 i_RESET_POS,
    input  logic                 i_DATA_READY,
    input  logic [31:0]          i_DATA,
    input  logic                 i_POP,
    output logic                 o_KEY_VALID,
    output logic [7:0]           o_KEY_CODE,
    output logic                 o_KEY_REPEAT,
    output logic                 o_KEY_HELD,
    output logic                 o_FIFO_FULL,
    output logic                 o_OVERFLOW,
    output logic [ERR_WIDTH-1:0] o_ERROR_COUNT,
    output logic [15:0]          o_LAST_ADDRESS
);

    localparam int TW = $clog2(RELEASE_CYCLES + 1);

    logic [1:0]    state;
    logic          ready_q;
    logic [31:0]   frame_q;
    logic [7:0]    last_cmd;
    logic          last_valid;
    logic [TW-1:0] timer;

    logic          frame_evt;
    logic [7:0]    f_addr;
    logic [7:0]    f_naddr;
    logic [7:0]    f_cmd;
    logic [7:0]    f_ncmd;
    logic          cmd_ok;
    logic          addr_ok;
    logic [15:0]   frame_addr;
    logic          addr_match;
    logic          rpt;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    key_entry_t    fifo_din;
    key_entry_t    fifo_head;
    logic          err_drop;
    logic          err_check;
    logic [ERR_WIDTH:0] err_sum;

    assign frame_evt  = i_DATA_READY && !ready_q;
    assign f_addr     = nec_field(frame_q, ADDR_LSB);
    assign f_naddr    = nec_field(frame_q, NADDR_LSB);
    assign f_cmd      = nec_field(frame_q, CMD_LSB);
    assign f_ncmd     = nec_field(frame_q, NCMD_LSB);
    assign cmd_ok     = (f_ncmd == ~f_cmd);
    assign addr_ok    = EXTENDED_ADDR || (f_naddr == ~f_addr);
    assign frame_addr = EXTENDED_ADDR ? frame_q[15:0] : {8'h00, f_addr};
    assign addr_match = !CHECK_ADDRESS || (frame_addr == ADDRESS);

    assign rpt       = last_valid && (f_cmd == last_cmd) && (timer != '0);
    assign fifo_push = (state == ST_PUSH);
    assign fifo_pop  = i_POP && !fifo_empty;
    assign fifo_din  = '{rpt: rpt, code: f_cmd};

    // A dropped event and a failed check can land in the same cycle.
    assign err_drop  = frame_evt && (state != ST_IDLE);
    assign err_check = (state == ST_CHECK) && !(cmd_ok && addr_ok);
    assign err_sum   = {1'b0, o_ERROR_COUNT} + (ERR_WIDTH+1)'(err_drop) + (ERR_WIDTH+1)'(err_check);

    ir_key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_key_fifo (
        .clk   (i_CLOCK_POS),
        .rst   (i_RESET_POS),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign o_KEY_VALID  = !fifo_empty;
    assign o_KEY_CODE   = fifo_empty ? 8'h00 : fifo_head.code;
    assign o_KEY_REPEAT = !fifo_empty && fifo_head.rpt;
    assign o_KEY_HELD   = (timer != '0);
    assign o_FIFO_FULL  = fifo_full;

    always_ff @(posedge i_CLOCK_POS) begin
        if (i_RESET_POS) begin
            state          <= ST_IDLE;
            ready_q        <= 1'b0;
            frame_q        <= '0;
            last_cmd       <= '0;
            last_valid     <= 1'b0;
            timer          <= '0;
            o_OVERFLOW     <= 1'b0;
            o_ERROR_COUNT  <= '0;
            o_LAST_ADDRESS <= '0;
        end else begin
            ready_q <= i_DATA_READY;

            if (err_sum[ERR_WIDTH]) begin
                o_ERROR_COUNT <= '1;
            end else begin
                o_ERROR_COUNT <= err_sum[ERR_WIDTH-1:0];
            end

            if (timer != '0) begin
                timer <= timer - 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (frame_evt) begin
                        frame_q <= i_DATA;
                        state   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!(cmd_ok && addr_ok)) begin
                        state <= ST_IDLE;
                    end else begin
                        o_LAST_ADDRESS <= frame_addr;
                        state          <= addr_match ? ST_PUSH : ST_IDLE;
                    end
                end
                ST_PUSH: begin
                    last_cmd   <= f_cmd;
                    last_valid <= 1'b1;
                    timer      <= TW'(RELEASE_CYCLES);
                    if (fifo_full && !fifo_pop) begin
                        o_OVERFLOW <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_command_decoder.sv
// Scoreboard bench for ir_command_decoder: stimulus queues expected key entries,
// a monitor pops the DUT FIFO and compares in order.
module tb_ir_command_decoder;

    logic        i_CLOCK_POS = 1'b0;
    logic        i_RESET_POS = 1'b1;
    logic        i_DATA_READY = 1'b0;
    logic [31:0] i_DATA = '0;
    logic        i_POP;
    logic        o_KEY_VALID;
    logic [7:0]  o_KEY_CODE;
    logic        o_KEY_REPEAT;
    logic        o_KEY_HELD;
    logic        o_FIFO_FULL;
    logic        o_OVERFLOW;
    logic [7:0]  o_ERROR_COUNT;
    logic [15:0] o_LAST_ADDRESS;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          p;
    logic        pop_en    = 1'b0;
    logic        mon_pop   = 1'b0;
    logic        force_pop = 1'b0;
    logic [8:0]  exp_q [$];

    assign i_POP = mon_pop | force_pop;

    ir_command_decoder #(
        .ADDRESS        (16'h0000),
        .CHECK_ADDRESS  (1'b1),
        .EXTENDED_ADDR  (1'b0),
        .FIFO_DEPTH     (4),
        .RELEASE_CYCLES (100),
        .ERR_WIDTH      (8)
    ) dut (
        .i_CLOCK_POS    (i_CLOCK_POS),
        .i_RESET_POS    (i_RESET_POS),
        .i_DATA_READY   (i_DATA_READY),
        .i_DATA         (i_DATA),
        .i_POP          (i_POP),
        .o_KEY_VALID    (o_KEY_VALID),
        .o_KEY_CODE     (o_KEY_CODE),
        .o_KEY_REPEAT   (o_KEY_REPEAT),
        .o_KEY_HELD     (o_KEY_HELD),
        .o_FIFO_FULL    (o_FIFO_FULL),
        .o_OVERFLOW     (o_OVERFLOW),
        .o_ERROR_COUNT  (o_ERROR_COUNT),
        .o_LAST_ADDRESS (o_LAST_ADDRESS)
    );

    always #5 i_CLOCK_POS = ~i_CLOCK_POS;

    always @(posedge i_CLOCK_POS) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Consumer side: pop one entry per cycle while enabled and compare with the queue.
    always @(negedge i_CLOCK_POS) begin
        if (pop_en && o_KEY_VALID) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_entry: got %0h expected none", {o_KEY_REPEAT, o_KEY_CODE});
            end else begin
                check("key_entry", {23'd0, o_KEY_REPEAT, o_KEY_CODE}, {23'd0, exp_q.pop_front()});
            end
            mon_pop = 1'b1;
        end else begin
            mon_pop = 1'b0;
        end
    end

    task automatic send_frame(input logic [31:0] d);
        i_DATA       = d;
        i_DATA_READY = 1'b1;
        @(negedge i_CLOCK_POS);
        i_DATA_READY = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && !o_KEY_VALID) break;
            @(negedge i_CLOCK_POS);
        end
        check("drain_done", {31'd0, (exp_q.size() == 0) && !o_KEY_VALID}, 32'd1);
    endtask

    function automatic logic [31:0] nec_frame(input logic [7:0] addr, input logic [7:0] cmd);
        return {~cmd, cmd, ~addr, addr};
    endfunction

    initial begin
        repeat (3) @(negedge i_CLOCK_POS);
        check("rst_valid",   {31'd0, o_KEY_VALID}, 32'd0);
        check("rst_code",    {24'd0, o_KEY_CODE}, 32'd0);
        check("rst_held",    {31'd0, o_KEY_HELD}, 32'd0);
        check("rst_errors",  {24'd0, o_ERROR_COUNT}, 32'd0);
        check("rst_lastadr", {16'd0, o_LAST_ADDRESS}, 32'd0);
        i_RESET_POS = 1'b0;
        @(negedge i_CLOCK_POS);

        // Basic frame: visible two edges after capture.
        send_frame(32'hBF40FF00);
        check("lat_n1_valid", {31'd0, o_KEY_VALID}, 32'd0);
        @(negedge i_CLOCK_POS);
        check("lat_n1_valid", {31'd0, o_KEY_VALID}, 32'd0);
        @(negedge i_CLOCK_POS);
        check("lat_n2_valid", {31'd0, o_KEY_VALID}, 32'd1);
        check("first_code",   {24'd0, o_KEY_CODE}, 32'h40);
        check("first_repeat", {31'd0, o_KEY_REPEAT}, 32'd0);
        check("first_lastadr", {16'd0, o_LAST_ADDRESS}, 32'h0000);
        check("first_held",   {31'd0, o_KEY_HELD}, 32'd1);
        p = cyc;
        exp_q.push_back({1'b0, 8'h40});
        pop_en = 1'b1;

        // Repeat within the release window, then a fresh press after it expires.
        while (cyc != p + 48) @(negedge i_CLOCK_POS);
        exp_q.push_back({1'b1, 8'h40});
        send_frame(32'hBF40FF00);
        repeat (2) @(negedge i_CLOCK_POS);
        p = cyc;
        while (cyc != p + 148) @(negedge i_CLOCK_POS);
        exp_q.push_back({1'b0, 8'h40});
        send_frame(32'hBF40FF00);
        repeat (2) @(negedge i_CLOCK_POS);
        p = cyc;
        while (cyc != p + 99) @(negedge i_CLOCK_POS);
        check("held_last_clock", {31'd0, o_KEY_HELD}, 32'd1);
        @(negedge i_CLOCK_POS);
        check("held_released", {31'd0, o_KEY_HELD}, 32'd0);
        wait_drain();

        // Malformed complements.
        send_frame(32'hBE40FF00);
        repeat (3) @(negedge i_CLOCK_POS);
        check("bad_cmd_err",   {24'd0, o_ERROR_COUNT}, 32'd1);
        check("bad_cmd_valid", {31'd0, o_KEY_VALID}, 32'd0);
        send_frame(32'hBF40FE00);
        repeat (3) @(negedge i_CLOCK_POS);
        check("bad_addr_err",  {24'd0, o_ERROR_COUNT}, 32'd2);

        // Address filter: valid frame for another device.
        send_frame(32'hBF40FE01);
        repeat (3) @(negedge i_CLOCK_POS);
        check("filter_err",     {24'd0, o_ERROR_COUNT}, 32'd2);
        check("filter_lastadr", {16'd0, o_LAST_ADDRESS}, 32'h0001);
        check("filter_valid",   {31'd0, o_KEY_VALID}, 32'd0);

        // Overflow: five keys into a four-entry FIFO.
        pop_en = 1'b0;
        @(negedge i_CLOCK_POS);
        for (int i = 1; i <= 5; i++) begin
            send_frame(nec_frame(8'h00, 8'(i)));
            repeat (3) @(negedge i_CLOCK_POS);
            if (i <= 4) exp_q.push_back({1'b0, 8'(i)});
        end
        check("ovf_full",  {31'd0, o_FIFO_FULL}, 32'd1);
        check("ovf_flag",  {31'd0, o_OVERFLOW}, 32'd1);
        check("ovf_head",  {24'd0, o_KEY_CODE}, 32'h01);
        check("ovf_err",   {24'd0, o_ERROR_COUNT}, 32'd2);
        pop_en = 1'b1;
        wait_drain();
        check("drained_full", {31'd0, o_FIFO_FULL}, 32'd0);
        check("ovf_sticky",   {31'd0, o_OVERFLOW}, 32'd1);
        pop_en = 1'b0;
        @(negedge i_CLOCK_POS);
        force_pop = 1'b1;
        @(negedge i_CLOCK_POS);
        force_pop = 1'b0;
        @(negedge i_CLOCK_POS);
        check("empty_pop_valid", {31'd0, o_KEY_VALID}, 32'd0);
        check("empty_pop_full",  {31'd0, o_FIFO_FULL}, 32'd0);
        check("empty_pop_err",   {24'd0, o_ERROR_COUNT}, 32'd2);

        // Reset while the frame sits in CHECK.
        send_frame(32'hBF40FF00);
        i_RESET_POS = 1'b1;
        @(negedge i_CLOCK_POS);
        check("midrst_valid",   {31'd0, o_KEY_VALID}, 32'd0);
        check("midrst_ovf",     {31'd0, o_OVERFLOW}, 32'd0);
        check("midrst_err",     {24'd0, o_ERROR_COUNT}, 32'd0);
        check("midrst_lastadr", {16'd0, o_LAST_ADDRESS}, 32'd0);
        check("midrst_held",    {31'd0, o_KEY_HELD}, 32'd0);
        i_RESET_POS = 1'b0;
        repeat (5) @(negedge i_CLOCK_POS);
        check("midrst_no_push", {31'd0, o_KEY_VALID}, 32'd0);

        // A long high level is a single frame event.
        i_DATA       = 32'hBE41FF00;
        i_DATA_READY = 1'b1;
        repeat (1000) @(negedge i_CLOCK_POS);
        i_DATA_READY = 1'b0;
        repeat (3) @(negedge i_CLOCK_POS);
        check("level_valid", {31'd0, o_KEY_VALID}, 32'd1);
        check("level_code",  {24'd0, o_KEY_CODE}, 32'h41);
        check("level_err",   {24'd0, o_ERROR_COUNT}, 32'd0);
        exp_q.push_back({1'b0, 8'h41});
        pop_en = 1'b1;
        wait_drain();
        repeat (3) @(negedge i_CLOCK_POS);
        check("level_single", {31'd0, o_KEY_VALID}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
